// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam int unsigned MEM_WORDS_DEFAULT = 8192;

    // Byte address to word index; addresses are byte-granular, memory is word-organised.
    function automatic logic [61:0] wordIndex(input logic [63:0] byteAddr);
        return 62'(byteAddr >> 2);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin (or fixed data-priority) arbiter sharing one memory between fetch and load/store.
// state | meaning
// IDLE  | sample requests, pick and latch the winner
// ACC   | drive the memory for exactly one cycle
// RESP  | pulse the winner's ack with rdata/err
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int unsigned MEM_WORDS  = MEM_WORDS_DEFAULT,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] adr,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] ReadData
);

    localparam logic [61:0] WORD_LIMIT = 62'(MEM_WORDS);

    state_t state, nextState;
    grant_t gnt, lastGrant, pick;
    logic   latWe, latOob;
    logic   doGrant;
    logic   iOob, dOob;

    assign iOob = wordIndex(64'(i_addr)) >= WORD_LIMIT;
    assign dOob = wordIndex(64'(d_addr)) >= WORD_LIMIT;

    // On a tie the data port wins unless it was the last port served (round-robin).
    always_comb begin
        pick = GNT_I;
        if (d_req && !i_req) begin
            pick = GNT_D;
        end else if (d_req && i_req) begin
            pick = (FIXED_PRIO || lastGrant == GNT_I) ? GNT_D : GNT_I;
        end
    end

    assign doGrant = (state == IDLE) && (i_req || d_req);

    always_comb begin
        nextState = state;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) nextState = ACC;
            end
            ACC: begin
                nextState = RESP;
                MemRead   = !latOob && !latWe;
                MemWrite  = !latOob && latWe;
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= GNT_I;
            lastGrant <= GNT_I;
            latWe     <= 1'b0;
            latOob    <= 1'b0;
            adr       <= '0;
            WriteData <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
        end else begin
            state <= nextState;
            i_ack <= 1'b0;
            d_ack <= 1'b0;

            // adr doubles as the latched address, so it holds its value outside ACC.
            if (doGrant) begin
                gnt       <= pick;
                lastGrant <= pick;
                if (pick == GNT_D) begin
                    adr    <= d_addr;
                    latWe  <= d_we;
                    latOob <= dOob;
                    if (d_we) WriteData <= d_wdata;
                end else begin
                    adr    <= i_addr;
                    latWe  <= 1'b0;
                    latOob <= iOob;
                end
            end

            if (state == ACC) begin
                i_ack <= (gnt == GNT_I);
                d_ack <= (gnt == GNT_D);
                err   <= latOob;
                if (latOob) begin
                    rdata <= '0;
                end else if (!latWe) begin
                    rdata <= ReadData;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized single-port traffic.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, err, MemRead, MemWrite;
    logic [31:0] rdata, adr, WriteData;
    wire  [31:0] ReadData;

    logic        fpIReq, fpDReq;
    logic        fpIAck, fpDAck, fpErr, fpMemRead, fpMemWrite;
    logic [31:0] fpRdata, fpAdr, fpWriteData;
    wire  [31:0] fpReadData;

    int          nCompared = 0;
    int          nMismatched = 0;
    logic [31:0] refMem [0:8191];
    logic [31:0] mem [0:8191];
    logic        preloaded;
    logic [31:0] expRdata;
    bit          expLastD;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(8192), .FIXED_PRIO(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .err(err),
        .adr(adr), .MemRead(MemRead), .MemWrite(MemWrite), .WriteData(WriteData),
        .ReadData(ReadData)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(8192), .FIXED_PRIO(1'b1)) u_dutFp (
        .clk(clk), .rst_n(rst_n),
        .i_req(fpIReq), .i_addr(i_addr), .i_ack(fpIAck),
        .d_req(fpDReq), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(fpDAck),
        .rdata(fpRdata), .err(fpErr),
        .adr(fpAdr), .MemRead(fpMemRead), .MemWrite(fpMemWrite), .WriteData(fpWriteData),
        .ReadData(fpReadData)
    );

    function automatic logic [31:0] seedWord(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory: combinational read, commit on the rising edge that ends ACC.
    assign ReadData   = MemRead   ? mem[adr[14:2]]   : 32'hzzzz_zzzz;
    assign fpReadData = fpMemRead ? mem[fpAdr[14:2]] : 32'hzzzz_zzzz;

    always @(posedge clk) begin
        if (preloaded !== 1'b1) begin
            for (int i = 0; i < 8192; i++) mem[i] <= seedWord(i);
            preloaded <= 1'b1;
        end else if (MemWrite) begin
            mem[adr[14:2]] <= WriteData;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            nCompared++;
            if (i_ack && d_ack) begin
                nMismatched++;
                $display("FAIL both_acks i_ack=%b d_ack=%b want at most one high", i_ack, d_ack);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; fpIReq = 1'b0; fpDReq = 1'b0;
        cyc(); cyc();
        rst_n    = 1'b1;
        expRdata = 32'h0;
        expLastD = 1'b0;
    endtask

    // One single-port access, starting in an IDLE cycle; requester inputs are disturbed during ACC.
    task automatic doAccess(input bit isData, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input string tag);
        bit inR;
        int idx;
        inR = (addr >> 2) < 32'd8192;
        idx = int'(addr[14:2]);
        if (isData) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        cyc();
        d_addr = addr + 32'h10; i_addr = addr + 32'h10; d_wdata = ~wdata; d_we = ~we;
        #1;
        nCompared++;
        if (MemRead !== (inR && !we)) begin
            nMismatched++;
            $display("FAIL %s MemRead got %b want %b", tag, MemRead, inR && !we);
        end
        nCompared++;
        if (MemWrite !== (inR && we)) begin
            nMismatched++;
            $display("FAIL %s MemWrite got %b want %b", tag, MemWrite, inR && we);
        end
        if (inR) begin
            nCompared++;
            if (adr !== addr) begin
                nMismatched++;
                $display("FAIL %s adr got %h want %h", tag, adr, addr);
            end
        end
        if (inR && we) begin
            nCompared++;
            if (WriteData !== wdata) begin
                nMismatched++;
                $display("FAIL %s WriteData got %h want %h", tag, WriteData, wdata);
            end
        end
        cyc();
        nCompared++;
        if (i_ack !== !isData || d_ack !== isData) begin
            nMismatched++;
            $display("FAIL %s ack got i=%b d=%b want i=%b d=%b", tag, i_ack, d_ack, !isData, isData);
        end
        nCompared++;
        if (err !== !inR) begin
            nMismatched++;
            $display("FAIL %s err got %b want %b", tag, err, !inR);
        end
        if (!inR) expRdata = 32'h0;
        else if (!we) expRdata = refMem[idx];
        else refMem[idx] = wdata;
        nCompared++;
        if (rdata !== expRdata) begin
            nMismatched++;
            $display("FAIL %s rdata got %h want %h", tag, rdata, expRdata);
        end
        i_req = 1'b0; d_req = 1'b0;
        cyc();
        nCompared++;
        if ((i_ack | d_ack) !== 1'b0) begin
            nMismatched++;
            $display("FAIL %s ack_width got i=%b d=%b want 0 0", tag, i_ack, d_ack);
        end
        expLastD = isData;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; fpIReq = 1'b0; fpDReq = 1'b0;
        d_we = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0;
        cyc(); cyc();
        nCompared++;
        if ({i_ack, d_ack, MemRead, MemWrite, err} !== 5'b0) begin
            nMismatched++;
            $display("FAIL reset_flags got %b want 00000", {i_ack, d_ack, MemRead, MemWrite, err});
        end
        nCompared++;
        if (adr !== 32'h0 || WriteData !== 32'h0 || rdata !== 32'h0) begin
            nMismatched++;
            $display("FAIL reset_data got adr=%h wd=%h rdata=%h want 0", adr, WriteData, rdata);
        end
        rst_n    = 1'b1;
        expRdata = 32'h0;
        expLastD = 1'b0;
    endtask

    task automatic test_write_read();
        doAccess(1'b1, 1'b1, 32'h3E8, 32'hDEAD_BEEF, "wr_3e8");
        doAccess(1'b1, 1'b0, 32'h3E8, 32'h0, "rd_3e8");
        nCompared++;
        if (rdata !== 32'hDEAD_BEEF) begin
            nMismatched++;
            $display("FAIL readback_3e8 got %h want deadbeef", rdata);
        end
    endtask

    task automatic test_out_of_range();
        doAccess(1'b1, 1'b0, 32'h8000, 32'h0, "oob_rd");
        doAccess(1'b0, 1'b0, 32'h7FFC, 32'h0, "last_word_fetch");
        doAccess(1'b1, 1'b1, 32'h8004, 32'h1234_5678, "oob_wr");
        doAccess(1'b0, 1'b0, 32'h0000_0104, 32'h0, "fetch_after_oob");
    endtask

    task automatic test_input_change();
        doAccess(1'b1, 1'b0, 32'h10, 32'h0, "addr_change");
    endtask

    task automatic test_contention();
        int  nAcks;
        int  lastAck;
        bit  wantD;
        logic [31:0] want;
        applyReset();
        i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        nAcks = 0; lastAck = 0;
        for (int k = 1; k <= 20 && nAcks < 4; k++) begin
            cyc();
            if (i_ack | d_ack) begin
                wantD = !expLastD;
                nCompared++;
                if (d_ack !== wantD || i_ack !== !wantD) begin
                    nMismatched++;
                    $display("FAIL rr_order ack#%0d got d=%b i=%b want d=%b", nAcks, d_ack, i_ack, wantD);
                end
                nCompared++;
                if (k - lastAck !== (nAcks == 0 ? 2 : 3)) begin
                    nMismatched++;
                    $display("FAIL rr_spacing ack#%0d got %0d want %0d", nAcks, k - lastAck, nAcks == 0 ? 2 : 3);
                end
                want = wantD ? refMem[32'h200 >> 2] : refMem[32'h100 >> 2];
                nCompared++;
                if (rdata !== want) begin
                    nMismatched++;
                    $display("FAIL rr_rdata ack#%0d got %h want %h", nAcks, rdata, want);
                end
                expRdata = want;
                expLastD = wantD;
                lastAck  = k;
                nAcks++;
            end
        end
        nCompared++;
        if (nAcks !== 4) begin
            nMismatched++;
            $display("FAIL rr_ack_count got %0d want 4", nAcks);
        end
        i_req = 1'b0; d_req = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_fixed_prio();
        int nI, nD;
        bit gotI;
        d_addr = 32'h200; i_addr = 32'h100; d_we = 1'b0;
        fpIReq = 1'b1; fpDReq = 1'b1;
        nI = 0; nD = 0;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            if (fpIAck) nI++;
            if (fpDAck) begin
                nD++;
                nCompared++;
                if (fpRdata !== refMem[32'h200 >> 2] || fpErr !== 1'b0) begin
                    nMismatched++;
                    $display("FAIL fp_rdata got %h err=%b want %h err=0", fpRdata, fpErr, refMem[32'h200 >> 2]);
                end
            end
        end
        nCompared++;
        if (nI !== 0 || nD !== 5) begin
            nMismatched++;
            $display("FAIL fp_starve got i=%0d d=%0d acks want i=0 d=5", nI, nD);
        end
        fpDReq = 1'b0;
        gotI = 1'b0;
        for (int k = 1; k <= 6 && !gotI; k++) begin
            cyc();
            if (fpIAck) gotI = 1'b1;
        end
        nCompared++;
        if (!gotI || fpRdata !== refMem[32'h100 >> 2]) begin
            nMismatched++;
            $display("FAIL fp_fetch_after got ack=%b rdata=%h want ack=1 rdata=%h", gotI, fpRdata, refMem[32'h100 >> 2]);
        end
        nCompared++;
        if (fpMemWrite !== 1'b0 || fpWriteData !== 32'h0) begin
            nMismatched++;
            $display("FAIL fp_no_write got we=%b wd=%h want 0 0", fpMemWrite, fpWriteData);
        end
        fpIReq = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_reset_mid();
        int nAck;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = ~refMem[16];
        cyc();
        nCompared++;
        if (MemWrite !== 1'b1) begin
            nMismatched++;
            $display("FAIL rstmid_acc got MemWrite=%b want 1", MemWrite);
        end
        #2 rst_n = 1'b0;
        #1;
        nCompared++;
        if (MemWrite !== 1'b0 || MemRead !== 1'b0) begin
            nMismatched++;
            $display("FAIL rstmid_strobes got rd=%b wr=%b want 0 0", MemRead, MemWrite);
        end
        d_req = 1'b0;
        cyc(); cyc();
        nCompared++;
        if (mem[16] !== refMem[16]) begin
            nMismatched++;
            $display("FAIL rstmid_mem got %h want %h", mem[16], refMem[16]);
        end
        rst_n    = 1'b1;
        expRdata = 32'h0;
        expLastD = 1'b0;
        nAck = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (d_ack | i_ack) nAck++;
        end
        nCompared++;
        if (nAck !== 0) begin
            nMismatched++;
            $display("FAIL rstmid_noack got %0d acks want 0", nAck);
        end
        nCompared++;
        if (adr !== 32'h0 || WriteData !== 32'h0 || rdata !== 32'h0 || err !== 1'b0) begin
            nMismatched++;
            $display("FAIL rstmid_outputs got adr=%h wd=%h rdata=%h err=%b want 0", adr, WriteData, rdata, err);
        end
    endtask

    task automatic test_back_to_back();
        i_req = 1'b1; i_addr = 32'h80;
        cyc(); cyc();
        nCompared++;
        if (i_ack !== 1'b1) begin
            nMismatched++;
            $display("FAIL b2b_first got i_ack=%b want 1", i_ack);
        end
        expLastD = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h84;
        cyc(); cyc(); cyc();
        nCompared++;
        if (d_ack !== !expLastD || i_ack !== expLastD) begin
            nMismatched++;
            $display("FAIL b2b_data_wins got d=%b i=%b want d=1 i=0", d_ack, i_ack);
        end
        nCompared++;
        if (rdata !== refMem[32'h84 >> 2]) begin
            nMismatched++;
            $display("FAIL b2b_data_rdata got %h want %h", rdata, refMem[32'h84 >> 2]);
        end
        d_req = 1'b0;
        cyc(); cyc(); cyc();
        nCompared++;
        if (i_ack !== 1'b1 || rdata !== refMem[32'h80 >> 2]) begin
            nMismatched++;
            $display("FAIL b2b_fetch got ack=%b rdata=%h want ack=1 rdata=%h", i_ack, rdata, refMem[32'h80 >> 2]);
        end
        i_req = 1'b0;
        cyc();
        expLastD = 1'b0;
        expRdata = refMem[32'h80 >> 2];
    endtask

    task automatic test_random();
        bit          isData, we;
        logic [31:0] addr;
        for (int n = 0; n < 60; n++) begin
            isData = 1'($urandom_range(0, 1));
            we     = isData ? 1'($urandom_range(0, 1)) : 1'b0;
            if ($urandom_range(0, 5) == 0) addr = 32'h8000 + 32'($urandom_range(0, 4095));
            else addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            doAccess(isData, we, addr, $urandom, "random");
            for (int g = $urandom_range(0, 2); g > 0; g--) cyc();
        end
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < 8192; i++) if (mem[i] !== refMem[i]) bad++;
        nCompared++;
        if (bad !== 0) begin
            nMismatched++;
            $display("FAIL memory_image got %0d differing words want 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) refMem[i] = seedWord(i);
        test_reset();
        test_write_read();
        test_out_of_range();
        test_input_change();
        test_contention();
        test_fixed_prio();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_memory_image();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got still running want finished");
        $fatal(1, "timeout");
    end

endmodule
